// File: rtl/apb_global_pkg.sv
// Shared APB types: FSM state encoding, captured-request record and bus defaults.
package apb_global_pkg;

  typedef enum logic [1:0] {
    IDLE_STATE   = 2'd0,
    SETUP_STATE  = 2'd1,
    ACCESS_STATE = 2'd2
  } operation_states_e;

  localparam int APB_ADDR_W         = 32;
  localparam int APB_DATA_W         = 64;
  localparam int APB_STRB_W         = APB_DATA_W / 8;
  localparam int APB_ID_W           = 3;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  // Request fields are sized for the widest supported bus; narrower ports zero-extend
  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] strb;
    logic [2:0]            prot;
    logic [APB_ID_W-1:0]   id;
  } apb_req_s;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter: searches from rr_ptr and advances past the winner on each grant.
module apb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [IDX_W-1:0] rr_ptr;
  logic             found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        gnt_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
        found   = 1'b1;
      end
    end
    if (en && found) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= '0;
    else if (en && found) rr_ptr <= IDX_W'((int'(gnt_idx) + 1) % NUM_REQ);
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port among NUM_REQ requesters: round-robin grant, SETUP/ACCESS
// sequencing, one-hot slave decode, pready timeout and an id-tagged response pulse.
module apb_master_arbiter
  import apb_global_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDRESS_WIDTH  = APB_ADDR_W,
  parameter int DATA_WIDTH     = APB_DATA_W,
  parameter int NO_OF_SLAVES   = 16,
  parameter int SLV_SEL_LSB    = 28,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                                  pclk,
  input  logic                                  preset,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0]                    req_write,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]      req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]         req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]     req_strb,
  input  logic [NUM_REQ*3-1:0]                  req_prot,
  output logic                                  rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]            rsp_id,
  output logic [DATA_WIDTH-1:0]                 rsp_rdata,
  output logic                                  rsp_slverr,
  output logic                                  rsp_timeout,
  output logic [NO_OF_SLAVES-1:0]               pselx,
  output logic                                  penable,
  output logic                                  pwrite,
  output logic [ADDRESS_WIDTH-1:0]              paddr,
  output logic [DATA_WIDTH-1:0]                 pwdata,
  output logic [DATA_WIDTH/8-1:0]               pstrb,
  output logic [2:0]                            pprot,
  input  logic [DATA_WIDTH-1:0]                 prdata,
  input  logic                                  pready,
  input  logic                                  pslverr
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SLV_W  = $clog2(NO_OF_SLAVES);
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);

  operation_states_e state, state_nxt;
  apb_req_s          sel_req;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   xfer_id;
  logic [SLV_W-1:0]  slv_idx;
  logic [CNT_W-1:0]  to_cnt;
  logic              accept_win, accept, cnt_hit, xfer_done, xfer_abort;

  assign accept_win = (state == IDLE_STATE) || ((state == ACCESS_STATE) && pready);
  assign accept     = |gnt;
  assign req_ready  = gnt;
  assign cnt_hit    = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign xfer_done  = (state == ACCESS_STATE) && pready;
  assign xfer_abort = (state == ACCESS_STATE) && !pready && cnt_hit;

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (pclk),
    .rst     (preset),
    .req     (req_valid),
    .en      (accept_win),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    sel_req       = '0;
    sel_req.write = req_write[gnt_idx];
    sel_req.addr  = APB_ADDR_W'(req_addr[gnt_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH]);
    sel_req.wdata = APB_DATA_W'(req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH]);
    sel_req.strb  = APB_STRB_W'(req_strb[gnt_idx*STRB_W +: STRB_W]);
    sel_req.prot  = req_prot[gnt_idx*3 +: 3];
    sel_req.id    = APB_ID_W'(gnt_idx);
  end

  always_ff @(posedge pclk) begin
    if (preset) state <= IDLE_STATE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE_STATE:   if (accept) state_nxt = SETUP_STATE;
      SETUP_STATE:  state_nxt = ACCESS_STATE;
      ACCESS_STATE: begin
        if (pready)       state_nxt = accept ? SETUP_STATE : IDLE_STATE;
        else if (cnt_hit) state_nxt = IDLE_STATE;
      end
      default:      state_nxt = IDLE_STATE;
    endcase
  end

  always_comb begin
    pselx = '0;
    if (state != IDLE_STATE) pselx[slv_idx] = 1'b1;
    penable = (state == ACCESS_STATE);
  end

  // Request capture: fields stay put from SETUP until the next accept
  always_ff @(posedge pclk) begin
    if (preset) begin
      paddr   <= '0;
      pwrite  <= 1'b0;
      pwdata  <= '0;
      pstrb   <= '0;
      pprot   <= '0;
      slv_idx <= '0;
      xfer_id <= '0;
    end else if (accept) begin
      paddr   <= ADDRESS_WIDTH'(sel_req.addr);
      pwrite  <= sel_req.write;
      pwdata  <= DATA_WIDTH'(sel_req.wdata);
      pstrb   <= sel_req.write ? STRB_W'(sel_req.strb) : '0;
      pprot   <= sel_req.prot;
      slv_idx <= sel_req.addr[SLV_SEL_LSB +: SLV_W];
      xfer_id <= ID_W'(sel_req.id);
    end else if (xfer_done || xfer_abort) begin
      pstrb   <= '0;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset)                    to_cnt <= '0;
    else if (accept)               to_cnt <= '0;
    else if (state == ACCESS_STATE) to_cnt <= to_cnt + CNT_W'(1);
  end

  // Response stage: a completing pready takes priority over an expiring counter
  always_ff @(posedge pclk) begin
    if (preset) begin
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= xfer_done || xfer_abort;
      if (xfer_done) begin
        rsp_id      <= xfer_id;
        rsp_rdata   <= pwrite ? '0 : prdata;
        rsp_slverr  <= pslverr;
        rsp_timeout <= 1'b0;
      end else if (xfer_abort) begin
        rsp_id      <= xfer_id;
        rsp_rdata   <= '0;
        rsp_slverr  <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares one APB master port between NUM_REQ on-chip requesters.
- Round-robin arbitration between requesters.
- Sequences the APB IDLE/SETUP/ACCESS protocol.
- Decodes the address into a one-hot pselx over NO_OF_SLAVES.
- Applies a pready timeout and returns a one-cycle response tagged with the requester id.
- Sits between the stimulus/DMA requesters and the APB slave bus.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ADDRESS_WIDTH, 32: paddr width.
- DATA_WIDTH, 64: pwdata/prdata width; pstrb width is DATA_WIDTH/8.
- NO_OF_SLAVES, 16: pselx width; must be a power of 2.
- SLV_SEL_LSB, 28: lowest paddr bit of the slave-select field; field is $clog2(NO_OF_SLAVES) bits wide.
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles without pready before abort (>=2).

Ports:
- pclk  in  1  clock. One clock; reset is synchronous and active-high.
- preset  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_write  in  NUM_REQ  1 = write.
- req_addr  in  NUM_REQ*ADDRESS_WIDTH  packed addresses, requester i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_strb  in  NUM_REQ*DATA_WIDTH/8  packed byte strobes.
- req_prot  in  NUM_REQ*3  packed pprot values.
- rsp_valid  out  1  response pulse.
- rsp_id  out  $clog2(NUM_REQ)  requester that owns the response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_slverr  out  1  pslverr, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- pselx  out  NO_OF_SLAVES  one-hot slave select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDRESS_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  DATA_WIDTH/8  APB strobes.
- pprot  out  3  APB protection.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset: after a pclk edge with preset=1, every output is 0, state is IDLE_STATE, RR pointer is 0, timeout counter is 0.
- Reset mid-transfer drops the transfer: no response, pselx/penable low on the next cycle.
- Accept window: IDLE_STATE, or ACCESS_STATE with pready=1.
  - req_ready is combinational: the arbiter grant gated by the accept window.
  - A request is accepted when req_valid[i] & req_ready[i].
  - Requesters hold all request fields stable while valid until accepted.
- Arbitration:
  - Round-robin, starting search at rr_ptr.
  - After a grant to index g, rr_ptr = (g+1) mod NUM_REQ.
  - Exactly one grant per accept; no grant when no valid request.
- On accept, the captured request is registered into paddr/pwrite/pwdata/pprot.
  - pstrb gets req_strb for writes and is forced to 0 for reads.
  - Slave index = addr[SLV_SEL_LSB +: $clog2(NO_OF_SLAVES)]; the id is stored.
- FSM:
  - IDLE_STATE -> SETUP_STATE on accept.
  - SETUP_STATE: pselx[idx]=1, penable=0. Lasts exactly one cycle, then ACCESS_STATE.
  - ACCESS_STATE: pselx[idx]=1, penable=1, timeout counter increments each cycle.
    - pready=1 with a new accept -> SETUP_STATE (back-to-back, penable drops for one cycle).
    - pready=1 with no accept -> IDLE_STATE; pselx, penable, pstrb cleared.
    - pready=0 and counter = TIMEOUT_CYCLES-1 -> IDLE_STATE as a timeout abort.
- Address, control and data are stable from SETUP through the end of ACCESS.
- Latency: accept at cycle T, SETUP at T+1, ACCESS at T+2. With pready=1 at T+2, rsp_valid=1 at T+3. Minimum of 3 cycles per transfer.
- Response (registered, single-cycle pulse, no backpressure):
  - rsp_id = owner of the transfer.
  - rsp_rdata = prdata sampled at pready for reads, 0 for writes.
  - rsp_slverr = pslverr sampled at pready.
  - rsp_timeout = 0.
- Timeout response: rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
- pslverr and prdata are ignored unless penable & pready.
- The timeout counter clears on entry to SETUP_STATE.
- A pready arriving in the same cycle the timeout fires wins: normal completion.
- A requester that is granted and then deasserts valid is a protocol violation; behaviour is not defined.

Decomposition:
- apb_global_pkg:
  - Reuse operation_states_e for the FSM.
  - Add typedef apb_req_s (write, addr, wdata, strb, prot, id).
  - Add the TIMEOUT_CYCLES default constant.
- Sub-module apb_rr_arbiter (NUM_REQ): inputs req vector, enable; outputs one-hot grant and grant index. Holds rr_ptr internally.

Test Plan:
- Single write:
  - Stimulus: req0 write, addr 0x3000_0010, wdata 0xDEAD_BEEF_0000_0001, strb 0xFF, pready high in ACCESS.
  - Response: pselx=0x0008 for 2 cycles; penable 0 then 1; rsp_valid at T+3 with id=0, slverr=0.
- Read with wait states:
  - Stimulus: req2 read, addr 0xF000_0000, pready low for 3 ACCESS cycles, then high with prdata 0x1234.
  - Response: pselx=0x8000; pstrb=0; rsp_rdata=0x1234; id=2; rsp_valid 6 cycles after accept.
- Round-robin:
  - Stimulus: all 4 requesters valid continuously.
  - Response: grant order 0,1,2,3,0. Back-to-back ACCESS->SETUP with no IDLE cycle; each response id matches the grant order.
- Timeout:
  - Stimulus: pready held 0.
  - Response: ACCESS lasts 16 cycles, then pselx=0. rsp_valid with slverr=1, timeout=1, rdata=0. Next request proceeds normally.
- Slave error:
  - Stimulus: pready=1 with pslverr=1 on a write.
  - Response: rsp_slverr=1, rsp_timeout=0.
- Reset mid-ACCESS:
  - Stimulus: preset=1 for 1 cycle during wait states.
  - Response: all outputs 0 on the next cycle, no rsp_valid, rr_ptr restarts at requester 0.
